vec_reg_chained: RTL
====================

Name: vec_reg_chained

Overview:
- One parametrised vector register with built-in write sequencing, chaining and scalar element access.
- Accepts a write stream from one of NSRC functional-unit result buses, or single scalar element writes from the S bus.
- Delivers a read stream with a fixed, parameter-set latency.
- Forwards in-flight write data to the read port during chain-slot time.
- Instantiated once per vector register in the vector unit; NVREG copies are placed there.

Parameters:
WIDTH, 64, element width in bits
DEPTH, 64, elements per register (power of 2)
LOGDEPTH, 6, log2(DEPTH)
NSRC, 8, number of functional-unit result buses
SRCW, 3, source select width, log2(NSRC)
RD_LAT, 3, pipeline registers after RAM read (minimum 1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_src_data  in  NSRC*WIDTH  FU result buses; source s occupies bits [s*WIDTH +: WIDTH]
i_sbus  in  WIDTH  scalar write data
i_vread_start  in  1  begin vector read stream
i_vwrite_start  in  1  begin vector write stream
i_swrite  in  1  scalar element write at i_ak
i_vector_length  in  LOGDEPTH+1  VL sampled on any start
i_vector_mask  in  DEPTH  element write mask sampled on i_vwrite_start
i_ak  in  LOGDEPTH  scalar element index
i_fu_time  in  4  FU latency sampled on i_vwrite_start
i_fu  in  SRCW  source select sampled on i_vwrite_start
o_rd_data  out  WIDTH  read stream data
o_rd_valid  out  1  o_rd_data holds a valid element
o_rd_last  out  1  qualifies the final element of the stream
o_busy  out  1  register reserved
o_chain_n  out  1  active-low chain-slot indicator

Behaviour:
- Reset: state IDLE; read_ptr, write_ptr and write_delay = 0; o_rd_valid, o_rd_last and o_busy = 0; o_chain_n = 1; o_rd_data = 0. RAM contents are not cleared. Reset mid-stream aborts the stream immediately; no further RAM writes occur.
- VL handling: VL sampled as 0 makes the start a no-op (state unchanged, no write). VL > DEPTH clamps to DEPTH.
- States: IDLE, READ, WRITE, CHAIN.
  - IDLE -> READ on i_vread_start.
  - IDLE -> WRITE on i_vwrite_start. If both starts are asserted together, read wins.
  - READ -> IDLE when read_ptr == VL-1 has been issued.
  - WRITE -> CHAIN on i_vread_start while elements remain.
  - WRITE -> READ on i_vread_start in the cycle the last element is written.
  - WRITE -> WRITE (restart) on i_vwrite_start in the last-element cycle.
  - WRITE -> IDLE after the last element is written.
  - CHAIN -> IDLE after the last element is written.
  - A start in any other state/cycle is ignored.
- Write timing:
  - On i_vwrite_start, write_delay <= i_fu_time + 4, then decrements to 0.
  - While write_delay == 0 and write_ptr < VL, element write_ptr is written each cycle with data i_src_data[cur_src].
  - RAM write enable = mask[write_ptr]; write_ptr advances regardless of the mask bit.
- Scalar write: i_swrite writes i_sbus to element i_ak in any state.
  - It has priority for the single RAM write port.
  - A colliding vector write stalls: write_ptr holds and the element is written the next cycle.
- Chain slot: o_chain_n = 0 exactly when write_delay == 2; otherwise 1.
- Read timing:
  - With N = the i_vread_start cycle, element i appears on o_rd_data with o_rd_valid = 1 in cycle N+RD_LAT+1+i.
  - o_rd_last is asserted with element VL-1.
  - When idle, read_ptr tracks i_ak, so scalar read data for element i_ak appears RD_LAT+1 cycles later.
- CHAIN mode: the read port outputs forwarded write data, registered once.
  - o_rd_valid pulses one cycle after each vector write cycle, including masked elements, whose data is forwarded unmasked.
  - o_rd_last is asserted with the forwarded element VL-1.
- o_busy: 1 in READ, WRITE and CHAIN. It drops to 0 in the last-element cycle of WRITE so a follow-on start can issue back-to-back.

Decomposition:
- Shared package vec_pkg holds:
  - the state enum (IDLE, READ, WRITE, CHAIN);
  - source codes VLOG=0, VSHIFT=1, VADD=2, FP_MUL=3, FP_ADD=4, FP_RA=5, VPOP=6, MEM=7;
  - constants WRITE_SLACK=4 and CHAIN_SLOT=2.
- Sub-module vec_ram: simple dual-port RAM (one write port, one synchronous read port), parameters WIDTH and DEPTH, no reset on the array.

Test Plan:
- Vector write, VL=5, fu_time=3, src 2 ramping 0x10.., mask all ones; then vector read -> RAM writes start 7 cycles after the start; the read returns 0x10..0x14 at cycles N+4..N+8 (RD_LAT=3); o_rd_last is asserted with 0x14.
- Vector write, VL=4, mask 4'b1010, with elements pre-filled with 0xAA -> read returns 0xAA, new1, 0xAA, new3.
- Vector write, VL=8, fu_time=2; vread_start during the cycle with o_chain_n=0 -> state CHAIN; 8 forwarded elements, each one cycle after its write; state IDLE after the 8th.
- i_swrite at i_ak=3 in the same cycle that vector element 3 would be written -> i_sbus lands first, vector element 3 the next cycle (final value = vector data); the stream still ends with 8 valid writes.
- rst asserted mid-read at element 10 of VL=64 -> o_rd_valid=0 next cycle, o_busy=0, state IDLE; an immediate new read starting after reset returns correct data.
- vwrite_start with VL=0 -> o_busy stays 0 and no RAM write occurs; VL=64 (equal to DEPTH) -> 64 writes, write_ptr wraps to 0 with no extra write.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector register file slice.
// No logic here: state encoding, functional-unit source codes, write timing constants.
// Imported by every vector register block.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    CHAIN = 2'd3
  } vstate_e;

  typedef enum logic [2:0] {
    VLOG   = 3'd0,
    VSHIFT = 3'd1,
    VADD   = 3'd2,
    FP_MUL = 3'd3,
    FP_ADD = 3'd4,
    FP_RA  = 3'd5,
    VPOP   = 3'd6,
    MEM    = 3'd7
  } src_e;

  // Cycles of slack added on top of the FU latency before the first element lands.
  localparam int WRITE_SLACK = 4;
  // write_delay value at which a chained reader may attach.
  localparam int CHAIN_SLOT  = 2;

endpackage

// File: rtl/vec_ram.sv
// Element storage: one write port, one synchronous read port, no reset on the array.
// Latency: read data registered, valid one cycle after the address.
// Backpressure: none; the write port is arbitrated by the owner.
module vec_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array write and registered read; a same-address read returns the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vec_reg_chained.sv
// One vector register: sequenced vector writes, scalar element writes, streamed reads, chaining.
// Latency: read element i appears RD_LAT+1+i cycles after the read start; chained data one cycle after its write.
// Backpressure: none; a scalar write steals the write port and stalls the vector write stream by one cycle.
module vec_reg_chained
  import vec_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 64,
  parameter int LOGDEPTH = 6,
  parameter int NSRC     = 8,
  parameter int SRCW     = 3,
  parameter int RD_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC*WIDTH-1:0] i_src_data,
  input  logic [WIDTH-1:0]      i_sbus,
  input  logic                  i_vread_start,
  input  logic                  i_vwrite_start,
  input  logic                  i_swrite,
  input  logic [LOGDEPTH:0]     i_vector_length,
  input  logic [DEPTH-1:0]      i_vector_mask,
  input  logic [LOGDEPTH-1:0]   i_ak,
  input  logic [3:0]            i_fu_time,
  input  logic [SRCW-1:0]       i_fu,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_last,
  output logic                  o_busy,
  output logic                  o_chain_n
);

  localparam int VLW = LOGDEPTH + 1;
  localparam int DW  = 5;  // holds i_fu_time + WRITE_SLACK (max 19)

  vstate_e            state_q, state_d;
  logic [VLW-1:0]     vl_q, vl_d;
  logic [VLW-1:0]     read_ptr_q, read_ptr_d;
  logic [VLW-1:0]     write_ptr_q, write_ptr_d;
  logic [DW-1:0]      write_delay_q, write_delay_d;
  logic [DEPTH-1:0]   mask_q, mask_d;
  logic [SRCW-1:0]    src_q, src_d;

  logic [VLW-1:0]      vl_in;
  logic                vl_zero;
  logic                rd_start_ok;
  logic                wr_start_ok;
  logic                wr_phase;
  logic                vwr_fire;
  logic                vwr_last;
  logic [WIDTH-1:0]    src_dat;
  logic                ram_we;
  logic [LOGDEPTH-1:0] ram_waddr;
  logic [WIDTH-1:0]    ram_wdata;
  logic [LOGDEPTH-1:0] ram_raddr;
  logic [WIDTH-1:0]    ram_rdata;
  logic                iss_vld;
  logic                iss_last;

  logic [WIDTH-1:0] pdat_q  [RD_LAT];
  logic [WIDTH-1:0] pdat_d  [RD_LAT];
  logic             pvld_q  [RD_LAT];
  logic             pvld_d  [RD_LAT];
  logic             plast_q [RD_LAT];
  logic             plast_d [RD_LAT];
  logic             s0_vld_q, s0_vld_d;
  logic             s0_last_q, s0_last_d;

  // Start qualification: zero length is a no-op, oversize lengths clamp to the register depth.
  always_comb begin
    vl_zero     = (i_vector_length == '0);
    vl_in       = (i_vector_length > VLW'(DEPTH)) ? VLW'(DEPTH) : i_vector_length;
    rd_start_ok = i_vread_start && !vl_zero;
    wr_start_ok = i_vwrite_start && !vl_zero;
  end

  // Vector write stream and write-port arbitration; scalar writes win and the stream holds.
  always_comb begin
    wr_phase  = ((state_q == WRITE) || (state_q == CHAIN)) &&
                (write_delay_q == '0) && (write_ptr_q < vl_q);
    vwr_fire  = wr_phase && !i_swrite;
    vwr_last  = vwr_fire && (write_ptr_q == vl_q - VLW'(1));
    src_dat   = i_src_data[src_q*WIDTH +: WIDTH];
    ram_we    = !rst && (i_swrite || (vwr_fire && mask_q[write_ptr_q[LOGDEPTH-1:0]]));
    ram_waddr = i_swrite ? i_ak : write_ptr_q[LOGDEPTH-1:0];
    ram_wdata = i_swrite ? i_sbus : src_dat;
  end

  // Sequencer: state transitions, pointer and delay updates, read issue.
  always_comb begin
    state_d       = state_q;
    vl_d          = vl_q;
    read_ptr_d    = read_ptr_q;
    write_ptr_d   = write_ptr_q;
    mask_d        = mask_q;
    src_d         = src_q;
    write_delay_d = (write_delay_q != '0) ? write_delay_q - DW'(1) : '0;
    ram_raddr     = i_ak;
    iss_vld       = 1'b0;
    iss_last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        read_ptr_d = {1'b0, i_ak};
        if (rd_start_ok) begin
          state_d    = READ;
          vl_d       = vl_in;
          read_ptr_d = VLW'(1);
          ram_raddr  = '0;
          iss_vld    = 1'b1;
          iss_last   = (vl_in == VLW'(1));
        end else if (wr_start_ok) begin
          state_d       = WRITE;
          vl_d          = vl_in;
          mask_d        = i_vector_mask;
          src_d         = i_fu;
          write_delay_d = DW'(i_fu_time) + DW'(WRITE_SLACK);
          write_ptr_d   = '0;
        end
      end
      READ: begin
        ram_raddr = read_ptr_q[LOGDEPTH-1:0];
        if (read_ptr_q < vl_q) begin
          iss_vld    = 1'b1;
          iss_last   = (read_ptr_q == vl_q - VLW'(1));
          read_ptr_d = read_ptr_q + VLW'(1);
        end
        if (read_ptr_q >= vl_q - VLW'(1)) begin
          state_d    = IDLE;
          read_ptr_d = '0;
        end
      end
      WRITE: begin
        if (vwr_fire) begin
          write_ptr_d = write_ptr_q + VLW'(1);
        end
        if (vwr_last) begin
          write_ptr_d = '0;
          if (rd_start_ok) begin
            state_d    = READ;
            vl_d       = vl_in;
            read_ptr_d = VLW'(1);
            ram_raddr  = '0;
            iss_vld    = 1'b1;
            iss_last   = (vl_in == VLW'(1));
          end else if (wr_start_ok) begin
            state_d       = WRITE;
            vl_d          = vl_in;
            mask_d        = i_vector_mask;
            src_d         = i_fu;
            write_delay_d = DW'(i_fu_time) + DW'(WRITE_SLACK);
          end else begin
            state_d = IDLE;
          end
        end else if (rd_start_ok) begin
          // The reader attaches to the in-flight stream and inherits its length.
          state_d = CHAIN;
        end
      end
      CHAIN: begin
        if (vwr_fire) begin
          write_ptr_d = write_ptr_q + VLW'(1);
        end
        if (vwr_last) begin
          write_ptr_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipeline; in CHAIN the last stage captures the write data instead of RAM data.
  always_comb begin
    s0_vld_d  = iss_vld;
    s0_last_d = iss_last;
    pdat_d[0]  = ram_rdata;
    pvld_d[0]  = s0_vld_q;
    plast_d[0] = s0_last_q;
    for (int j = 1; j < RD_LAT; j++) begin
      pdat_d[j]  = pdat_q[j-1];
      pvld_d[j]  = pvld_q[j-1];
      plast_d[j] = plast_q[j-1];
    end
    if (state_q == CHAIN) begin
      pdat_d[RD_LAT-1]  = src_dat;
      pvld_d[RD_LAT-1]  = vwr_fire;
      plast_d[RD_LAT-1] = vwr_last;
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      vl_q          <= '0;
      read_ptr_q    <= '0;
      write_ptr_q   <= '0;
      write_delay_q <= '0;
      mask_q        <= '0;
      src_q         <= '0;
      s0_vld_q      <= 1'b0;
      s0_last_q     <= 1'b0;
      for (int j = 0; j < RD_LAT; j++) begin
        pdat_q[j]  <= '0;
        pvld_q[j]  <= 1'b0;
        plast_q[j] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      vl_q          <= vl_d;
      read_ptr_q    <= read_ptr_d;
      write_ptr_q   <= write_ptr_d;
      write_delay_q <= write_delay_d;
      mask_q        <= mask_d;
      src_q         <= src_d;
      s0_vld_q      <= s0_vld_d;
      s0_last_q     <= s0_last_d;
      for (int j = 0; j < RD_LAT; j++) begin
        pdat_q[j]  <= pdat_d[j];
        pvld_q[j]  <= pvld_d[j];
        plast_q[j] <= plast_d[j];
      end
    end
  end

  vec_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign o_rd_data  = pdat_q[RD_LAT-1];
  assign o_rd_valid = pvld_q[RD_LAT-1];
  assign o_rd_last  = plast_q[RD_LAT-1];
  // Busy drops in the final write cycle so a follow-on start can issue back-to-back.
  assign o_busy     = (state_q != IDLE) && !((state_q == WRITE) && vwr_last);
  assign o_chain_n  = (write_delay_q != DW'(CHAIN_SLOT));

endmodule
